// File: rtl/cmp_node_nic.sv
// Node NIC: bridges a CPU's 2-bit-addressed register port to a mesh router port
// with one-packet input and output channel buffers.
module cmp_node_nic #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned VC_BIT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic [0:DATA_W-1] d_in,
  output logic [0:DATA_W-1] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  output logic              net_si,
  input  logic              net_ri,
  output logic [0:DATA_W-1] net_di,
  input  logic              net_so,
  output logic              net_ro,
  input  logic [0:DATA_W-1] net_do,
  input  logic              net_polarity
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} chan_state_e;

  chan_state_e       in_state_q, out_state_q;
  logic [0:DATA_W-1] in_buf_q, out_buf_q;
  logic              rd_en, wr_en, in_full, out_full;

  assign rd_en    = nicEn & ~nicWrEn;
  assign wr_en    = nicEn & nicWrEn;
  assign in_full  = (in_state_q == FULL);
  assign out_full = (out_state_q == FULL);

  assign net_ro = ~in_full;
  assign net_di = out_buf_q;
  // Gated by reset so a pending send is withdrawn in the cycle reset is sampled.
  assign net_si = ~reset & out_full & net_ri & (out_buf_q[VC_BIT] == net_polarity);

  always_ff @(posedge clk) begin
    if (reset) begin
      in_state_q  <= EMPTY;
      out_state_q <= EMPTY;
      in_buf_q    <= '0;
      out_buf_q   <= '0;
    end else begin
      case (in_state_q)
        EMPTY: if (net_so) begin
          in_buf_q   <= net_do;
          in_state_q <= FULL;
        end
        FULL: if (rd_en && addr == 2'd0) in_state_q <= EMPTY;
        default: in_state_q <= EMPTY;
      endcase

      // Stores while FULL are dropped even if the send completes this cycle.
      case (out_state_q)
        EMPTY: if (wr_en && addr == 2'd2) begin
          out_buf_q   <= d_in;
          out_state_q <= FULL;
        end
        FULL: if (net_si) out_state_q <= EMPTY;
        default: out_state_q <= EMPTY;
      endcase
    end
  end

  always_comb begin
    d_out = '0;
    if (rd_en) begin
      case (addr)
        2'd0: d_out = in_buf_q;
        2'd1: d_out[DATA_W-1] = in_full;
        2'd2: d_out = out_buf_q;
        2'd3: d_out[DATA_W-1] = out_full;
        default: d_out = '0;
      endcase
    end
  end

endmodule
